// File: rtl/sync_meas.sv
// Sync measurement for the latched TVP7002 HSYNC/VSYNC in the PCLK_in domain:
// line length, lines per field, clocks per frame, interlace and horizontal stability.
`timescale 1ns/1ps
module sync_meas #(
    parameter int H_TOL        = 2,
    parameter int STABLE_LINES = 16
) (
    input  logic        PCLK_in,
    input  logic        reset_n,
    input  logic        HSYNC_in,
    input  logic        VSYNC_in,
    output logic [11:0] pcnt_line,
    output logic [10:0] vmax,
    output logic [19:0] pcnt_frame,
    output logic        ilace_flag,
    output logic        h_unstable,
    output logic        vsync_flag
);
    localparam int            SW       = $clog2(STABLE_LINES + 1);
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_LINES);
    localparam logic [11:0]   TOL      = 12'(H_TOL);

    logic        hs_prev_q, vs_prev_q, vsync_flag_q;
    logic [11:0] h_cnt_q, h_cnt_d;
    logic [SW-1:0] stab_q, stab_d;
    logic [11:0] pcnt_line_q, pcnt_line_d;
    logic        h_unst_q, h_unst_d;
    logic [10:0] v_cnt_q, v_cnt_d;
    logic [19:0] f_cnt_q, f_cnt_d;
    logic [10:0] vmax_q, vmax_d;
    logic [19:0] pcnt_frame_q, pcnt_frame_d;
    logic        ilace_q, ilace_d;
    logic        fld_odd_prev_q, fld_odd_prev_d;
    logic [10:0] prev_lines_q, prev_lines_d;

    logic        hs_edge, vs_edge, h_sat, in_tol, fld_odd, ilace_new;
    logic [12:0] len_ext;
    logic [11:0] len, h_diff, fld_ext;
    logic [10:0] fld_lines;
    logic [20:0] frame_ext;

    assign hs_edge   = hs_prev_q & ~HSYNC_in;
    assign vs_edge   = vs_prev_q & ~VSYNC_in;
    assign h_sat     = (h_cnt_q == 12'hFFF);
    assign len_ext   = {1'b0, h_cnt_q} + 13'd1;
    assign len       = len_ext[12] ? 12'hFFF : len_ext[11:0];
    assign h_diff    = (len >= pcnt_line_q) ? (len - pcnt_line_q) : (pcnt_line_q - len);
    // a saturated counter means the line was lost, never a valid length
    assign in_tol    = (h_diff <= TOL) && !h_sat;
    // an hsync edge coincident with vsync closes the ending field
    assign fld_ext   = {1'b0, v_cnt_q} + {11'd0, hs_edge};
    assign fld_lines = fld_ext[11] ? 11'h7FF : fld_ext[10:0];
    assign frame_ext = {1'b0, f_cnt_q} + 21'd1;
    assign fld_odd   = (h_cnt_q >= (pcnt_line_q >> 1));
    assign ilace_new = fld_odd ^ fld_odd_prev_q;

    always_comb begin
        h_cnt_d     = h_cnt_q;
        stab_d      = stab_q;
        pcnt_line_d = pcnt_line_q;
        h_unst_d    = h_unst_q;
        if (hs_edge) begin
            h_cnt_d     = 12'd0;
            pcnt_line_d = len;
            if (in_tol) begin
                if (stab_q != STAB_MAX) stab_d = stab_q + 1'b1;
                if (stab_d == STAB_MAX) h_unst_d = 1'b0;
            end else begin
                stab_d   = '0;
                h_unst_d = 1'b1;
            end
        end else if (h_sat) begin
            stab_d   = '0;
            h_unst_d = 1'b1;
        end else begin
            h_cnt_d = h_cnt_q + 12'd1;
        end
    end

    always_comb begin
        v_cnt_d        = v_cnt_q;
        f_cnt_d        = f_cnt_q;
        vmax_d         = vmax_q;
        pcnt_frame_d   = pcnt_frame_q;
        ilace_d        = ilace_q;
        fld_odd_prev_d = fld_odd_prev_q;
        prev_lines_d   = prev_lines_q;
        if (hs_edge && v_cnt_q != 11'h7FF) v_cnt_d = v_cnt_q + 11'd1;
        if (f_cnt_q != 20'hFFFFF) f_cnt_d = f_cnt_q + 20'd1;
        if (vs_edge) begin
            v_cnt_d        = 11'd0;
            f_cnt_d        = 20'd0;
            pcnt_frame_d   = frame_ext[20] ? 20'hFFFFF : frame_ext[19:0];
            ilace_d        = ilace_new;
            fld_odd_prev_d = fld_odd;
            prev_lines_d   = fld_lines;
            vmax_d         = (ilace_new && prev_lines_q > fld_lines) ? prev_lines_q : fld_lines;
        end
    end

    always_ff @(posedge PCLK_in or negedge reset_n) begin
        if (!reset_n) begin
            hs_prev_q      <= 1'b1;
            vs_prev_q      <= 1'b1;
            vsync_flag_q   <= 1'b0;
            h_cnt_q        <= '0;
            stab_q         <= '0;
            pcnt_line_q    <= '0;
            h_unst_q       <= 1'b1;
            v_cnt_q        <= '0;
            f_cnt_q        <= '0;
            vmax_q         <= '0;
            pcnt_frame_q   <= '0;
            ilace_q        <= 1'b0;
            fld_odd_prev_q <= 1'b0;
            prev_lines_q   <= '0;
        end else begin
            hs_prev_q      <= HSYNC_in;
            vs_prev_q      <= VSYNC_in;
            vsync_flag_q   <= ~VSYNC_in;
            h_cnt_q        <= h_cnt_d;
            stab_q         <= stab_d;
            pcnt_line_q    <= pcnt_line_d;
            h_unst_q       <= h_unst_d;
            v_cnt_q        <= v_cnt_d;
            f_cnt_q        <= f_cnt_d;
            vmax_q         <= vmax_d;
            pcnt_frame_q   <= pcnt_frame_d;
            ilace_q        <= ilace_d;
            fld_odd_prev_q <= fld_odd_prev_d;
            prev_lines_q   <= prev_lines_d;
        end
    end

    assign pcnt_line  = pcnt_line_q;
    assign vmax       = vmax_q;
    assign pcnt_frame = pcnt_frame_q;
    assign ilace_flag = ilace_q;
    assign h_unstable = h_unst_q;
    assign vsync_flag = vsync_flag_q;
endmodule

// File: tb/tb_sync_meas.sv
// Bench for sync_meas: table of lines with expected line/frame results fed to
// scoreboards, plus sequences for hsync loss, interlace, coincident edges, reset.
`timescale 1ns/1ps
module tb_sync_meas;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hs = 1'b1;
    logic        vs = 1'b1;
    logic [11:0] pcnt_line;
    logic [10:0] vmax;
    logic [19:0] pcnt_frame;
    logic        ilace_flag, h_unstable, vsync_flag;

    always #5 clk = ~clk;

    sync_meas #(.H_TOL(2), .STABLE_LINES(16)) dut (
        .PCLK_in(clk), .reset_n(rst_n), .HSYNC_in(hs), .VSYNC_in(vs),
        .pcnt_line(pcnt_line), .vmax(vmax), .pcnt_frame(pcnt_frame),
        .ilace_flag(ilace_flag), .h_unstable(h_unstable), .vsync_flag(vsync_flag)
    );

    typedef struct {
        int len; int vs_off; int e_pcnt; bit e_unst; int e_vmax; int e_frame; bit e_ilace;
    } vec_t;
    typedef struct { int pcnt; bit unst; } hs_exp_t;
    typedef struct { int vmax; int frame; bit ilace; } vs_exp_t;

    int      n_tests = 0;
    int      n_fail  = 0;
    hs_exp_t hs_q[$];
    vs_exp_t vs_q[$];
    hs_exp_t he;
    vs_exp_t ve;
    vs_exp_t vs_pend;
    bit      vs_want = 1'b0;
    vec_t    tbl[40];

    task automatic check(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // bench-side sync edge monitor: results are due one clock after the edge
    logic hs_seen, vs_seen, hs_evt, vs_evt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_seen <= 1'b1; vs_seen <= 1'b1; hs_evt <= 1'b0; vs_evt <= 1'b0;
        end else begin
            hs_seen <= hs; vs_seen <= vs;
            hs_evt  <= hs_seen & ~hs;
            vs_evt  <= vs_seen & ~vs;
        end
    end

    always @(negedge clk) begin
        if (rst_n && hs_evt && hs_q.size() > 0) begin
            he = hs_q.pop_front();
            check("pcnt_line", int'(pcnt_line), he.pcnt);
            check("h_unstable", int'(h_unstable), int'(he.unst));
        end
        if (rst_n && vs_evt && vs_q.size() > 0) begin
            ve = vs_q.pop_front();
            check("vmax", int'(vmax), ve.vmax);
            check("pcnt_frame", int'(pcnt_frame), ve.frame);
            check("ilace_flag", int'(ilace_flag), int'(ve.ilace));
            check("vsync_flag", int'(vsync_flag), 1);
        end
    end

    // one line of len clocks starting with its hsync edge; vsync falls at vs_off
    task automatic run_line(int len, int vs_off);
        for (int i = 0; i < len; i++) begin
            hs = (i < 8) ? 1'b0 : 1'b1;
            if (vs_off >= 0 && i == vs_off) begin
                vs = 1'b0;
                if (vs_want) begin
                    vs_q.push_back(vs_pend);
                    vs_want = 1'b0;
                end
            end else if (vs_off >= 0 && i == vs_off + 4) begin
                vs = 1'b1;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_field(int n, int len, int vs_off, bit chk, int ev, int ef, bit ei);
        for (int k = 0; k < n - 1; k++) run_line(len, -1);
        if (chk) begin
            vs_pend = '{ev, ef, ei};
            vs_want = 1'b1;
        end
        run_line(len, vs_off);
    endtask

    task automatic check_reset_values(string tag);
        check({tag, "_pcnt_line"}, int'(pcnt_line), 0);
        check({tag, "_vmax"}, int'(vmax), 0);
        check({tag, "_pcnt_frame"}, int'(pcnt_frame), 0);
        check({tag, "_ilace"}, int'(ilace_flag), 0);
        check({tag, "_h_unstable"}, int'(h_unstable), 1);
        check({tag, "_vsync_flag"}, int'(vsync_flag), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        // 858-clock lines, one 860/858 jitter stretch and one 870 spike
        for (int k = 0; k < 40; k++) begin
            tbl[k] = '{858, -1, 858, 1'b0, 0, 0, 1'b0};
            if (k <= 15 || (k >= 21 && k <= 37)) tbl[k].e_unst = 1'b1;
        end
        tbl[2]  = '{858, 11, 858, 1'b1, 3, 2585, 1'b0};
        tbl[12] = '{858, 11, 858, 1'b1, 10, 8580, 1'b0};
        tbl[17] = '{860, -1, 858, 1'b0, 0, 0, 1'b0};
        tbl[18] = '{858, -1, 860, 1'b0, 0, 0, 1'b0};
        tbl[19] = '{860, -1, 858, 1'b0, 0, 0, 1'b0};
        tbl[20] = '{870, -1, 860, 1'b0, 0, 0, 1'b0};
        tbl[21] = '{858, -1, 870, 1'b1, 0, 0, 1'b0};
        tbl[22] = '{858, 11, 858, 1'b1, 10, 8596, 1'b0};

        repeat (4) @(negedge clk);
        check_reset_values("rst");
        rst_n = 1'b1;
        repeat (857) @(negedge clk);

        for (int k = 0; k < 40; k++) begin
            hs_q.push_back('{tbl[k].e_pcnt, tbl[k].e_unst});
            if (tbl[k].vs_off >= 0) begin
                vs_pend = '{tbl[k].e_vmax, tbl[k].e_frame, tbl[k].e_ilace};
                vs_want = 1'b1;
            end
            run_line(tbl[k].len, tbl[k].vs_off);
        end

        // hsync loss: h_unstable rises on the clock where h_cnt sits at 4095
        hs_q.push_back('{858, 1'b0});
        hs = 1'b0;
        repeat (8) @(negedge clk);
        hs = 1'b1;
        repeat (4096 - 8) @(negedge clk);
        check("loss_unst_before", int'(h_unstable), 0);
        @(negedge clk);
        check("loss_unst_at", int'(h_unstable), 1);
        check("loss_pcnt_held", int'(pcnt_line), 858);
        repeat (50) @(negedge clk);
        check("loss_unst_held", int'(h_unstable), 1);
        check("loss_pcnt_held2", int'(pcnt_line), 858);

        // interlace: 200-clock lines, fields of 6/7 lines, vsync at h_cnt 5 / 105
        run_line(200, -1);
        run_line(200, -1);
        run_field(1, 200, 6, 1'b0, 0, 0, 1'b0);
        run_field(6, 200, 6, 1'b1, 6, 1200, 1'b0);
        run_field(7, 200, 106, 1'b1, 7, 1500, 1'b1);
        run_field(6, 200, 6, 1'b1, 7, 1100, 1'b1);
        run_field(7, 200, 106, 1'b1, 7, 1500, 1'b1);

        // coincident hsync/vsync edges, 100 lines of 40 clocks
        run_field(1, 40, 0, 1'b0, 0, 0, 1'b0);
        run_field(100, 40, 0, 1'b1, 100, 4000, 1'b0);
        run_field(100, 40, 0, 1'b1, 100, 4000, 1'b0);

        // asynchronous reset in the middle of a line
        hs = 1'b0;
        repeat (8) @(negedge clk);
        hs = 1'b1;
        repeat (12) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_values("midrst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        for (int k = 1; k <= 18; k++) begin
            hs_q.push_back('{(k == 1) ? 11 : 40, (k == 18) ? 1'b0 : 1'b1});
            run_line(40, (k == 18) ? 0 : -1);
        end
        run_field(20, 40, 0, 1'b1, 20, 800, 1'b0);

        check("hs_queue_drained", hs_q.size(), 0);
        check("vs_queue_drained", vs_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
